pc_redirect_ctrl: RTL and testbench

Sequencer that drives the next-PC mux select and the interrupt/exception redirect of the 5-stage MIPS pipeline. It owns the CP0 state (SR, Cause, EPC, PRId), decides each cycle whether fetch continues sequentially, takes a D-stage branch/jump/jr target, returns through `eret`, or enters the handler at 0x0000_4180. It also produces the pipeline flush and the `eret` hazard stall. It sits between the decode/M-stage control and the next-PC mux.

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/cp0_regs.sv | 107 ++++++++++
 rtl/pc_redirect_ctrl.sv | 153 +++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the MIPS pipeline PC-redirect / CP0 logic.
//   Contents:
//     - next-PC mux select encodings (PCSEL_*)
//     - CP0 register numbers (SR, Cause, EPC, PRId)
//     - ExcCode constants
//     - handler entry address and PRId contents
//     - redirect sequencer state type
// ----------------------------------------------------------------------------
package cpu_pkg;

   // Next-PC mux select
   localparam logic [1:0] PCSEL_SEQ = 2'b00;  // PC+4
   localparam logic [1:0] PCSEL_JR  = 2'b01;  // jr/jalr register
   localparam logic [1:0] PCSEL_NPC = 2'b10;  // branch/jump target
   localparam logic [1:0] PCSEL_EPC = 2'b11;  // eret return

   // CP0 register numbers
   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   // ExcCode values
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
   localparam logic [31:0] PRID_VAL     = 32'h0000_0000;

   // Redirect sequencer states
   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_ENTER     = 2'd1,
      ST_ERET_WAIT = 2'd2
   } state_t;

   // Pack SR into its architectural layout: IM[15:10], EXL[1], IE[0].
   function automatic logic [31:0] pack_sr(input logic [5:0] im,
                                           input logic       exl,
                                           input logic       ie);
      pack_sr = {16'h0000, im, 8'h00, exl, ie};
   endfunction

   // Pack Cause: BD[31], IP[15:10], ExcCode[6:2].
   function automatic logic [31:0] pack_cause(input logic       bd,
                                              input logic [5:0] ip,
                                              input logic [4:0] code);
      pack_cause = {bd, 15'h0000, ip, 3'b000, code, 2'b00};
   endfunction

endpackage

// File: rtl/cp0_regs.sv
// ----------------------------------------------------------------------------
// cp0_regs
//   CP0 register file (SR, Cause, EPC, PRId) with mtc0 write decode, mfc0
//   read mux and the exception/interrupt entry update.
//   Build option: PC_REDIRECT_BD_EN -- when defined, a faulting delay-slot
//   instruction records EPC = pc_m - 4 and Cause.BD = 1.
//   Ports:
//     clk, reset        clock, async active-high reset
//     hw_int[5:0]       interrupt lines, sampled into Cause.IP each cycle
//     take, irq         entry this cycle / entry caused by an interrupt
//     exc_code_m[4:0]   ExcCode of the M-stage exception
//     pc_m[31:0], bd_m  M-stage PC and delay-slot flag
//     exl_clr           eret retires this cycle: clear SR.EXL
//     we, addr, wdata   mtc0 port (already suppressed on entry by the top)
//     im, ie, exl       SR fields for the interrupt qualifier
//     epc               current EPC
//     rdata             mfc0 read data for addr
// ----------------------------------------------------------------------------
module cp0_regs
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  hw_int,
   input  logic        take,
   input  logic        irq,
   input  logic [4:0]  exc_code_m,
   input  logic [31:0] pc_m,
   input  logic        bd_m,
   input  logic        exl_clr,
   input  logic        we,
   input  logic [4:0]  addr,
   input  logic [31:0] wdata,
   output logic [5:0]  im,
   output logic        ie,
   output logic        exl,
   output logic [31:0] epc,
   output logic [31:0] rdata
);

   logic [5:0] ip_hw;     // last sampled hw_int
   logic [1:0] ip_sw;     // software interrupt bits Cause.IP[11:10]
   logic       bd;
   logic [4:0] exc_code;

`ifndef PC_REDIRECT_BD_EN
   // Delay-slot tracking is compiled out; bd_m has no consumer in this build.
   logic unused_bd_m;
   assign unused_bd_m = bd_m;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         im       <= '0;
         ie       <= 1'b0;
         exl      <= 1'b0;
         ip_hw    <= '0;
         ip_sw    <= '0;
         bd       <= 1'b0;
         exc_code <= '0;
         epc      <= '0;
      end else begin
         ip_hw <= hw_int;
         if (take) begin
            // Entry owns the CP0 state this cycle; any mtc0 is dropped.
            exl      <= 1'b1;
            exc_code <= irq ? EXC_INT : exc_code_m;
`ifdef PC_REDIRECT_BD_EN
            bd       <= bd_m;
            epc      <= bd_m ? (pc_m - 32'd4) : pc_m;
`else
            bd       <= 1'b0;
            epc      <= pc_m;
`endif
         end else begin
            if (we) begin
               case (addr)
                  CP0_SR: begin
                     im  <= wdata[15:10];
                     exl <= wdata[1];
                     ie  <= wdata[0];
                  end
                  CP0_CAUSE: ip_sw <= wdata[11:10];
                  CP0_EPC:   epc   <= wdata;
                  default:   ;
               endcase
            end
            // eret leaving exception level wins over a same-cycle SR write.
            if (exl_clr) begin
               exl <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         CP0_SR:    rdata = pack_sr(im, exl, ie);
         CP0_CAUSE: rdata = pack_cause(bd, ip_hw | {4'b0000, ip_sw}, exc_code);
         CP0_EPC:   rdata = epc;
         CP0_PRID:  rdata = PRID_VAL;
         default:   rdata = '0;
      endcase
   end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// ----------------------------------------------------------------------------
// pc_redirect_ctrl
//   Next-PC sequencer for the 5-stage MIPS pipeline: chooses PC+4, jr target,
//   branch/jump target or EPC, enters the handler at HANDLER_ADDR on an
//   interrupt or M-stage exception, and generates the flush and eret stall.
//   Build option: PC_REDIRECT_BD_EN (delay-slot EPC/BD recording, in cp0_regs).
//
//   Handshake note: there is no valid/ready pair here; stall and eret_stall
//   are level hold requests, and an asserted stall forces pc_sel to PC+4 while
//   the hazard unit freezes the PC register itself.
//
//   Ports:
//     clk, reset                   clock, async active-high reset
//     stall                        D-stage hazard stall
//     br_taken_d, j_d, jr_d, eret_d  D-stage control-flow decode
//     exc_m, exc_code_m, pc_m, bd_m  M-stage exception info
//     hw_int[5:0]                  external interrupt lines
//     cp0_we_m, cp0_addr_m, cp0_wdata_m  mtc0/mfc0 at M
//     epc_wr_pend                  mtc0 to EPC in flight in E or M
//     pc_sel[1:0]                  next-PC mux select
//     int_take                     next PC is HANDLER_ADDR
//     epc_out                      EPC to the mux
//     flush                        clear IF/ID, ID/EX, EX/MEM
//     eret_stall                   extra D-stall for the eret/EPC hazard
//     cp0_rdata                    mfc0 read data
//     dbg_state[1:0]               sequencer state (state_t encoding)
// ----------------------------------------------------------------------------
module pc_redirect_ctrl
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_taken_d,
   input  logic        j_d,
   input  logic        jr_d,
   input  logic        eret_d,
   input  logic        exc_m,
   input  logic [4:0]  exc_code_m,
   input  logic [31:0] pc_m,
   input  logic        bd_m,
   input  logic [5:0]  hw_int,
   input  logic        cp0_we_m,
   input  logic [4:0]  cp0_addr_m,
   input  logic [31:0] cp0_wdata_m,
   input  logic        epc_wr_pend,
   output logic [1:0]  pc_sel,
   output logic        int_take,
   output logic [31:0] epc_out,
   output logic        flush,
   output logic        eret_stall,
   output logic [31:0] cp0_rdata,
   output logic [1:0]  dbg_state
);

   state_t      state, state_nxt;
   logic [5:0]  im;
   logic        ie, exl;
   logic [31:0] epc;
   logic [31:0] rdata;
   logic        irq, take;
   logic        stall_eret;
   logic        redirect_ok;
   logic [1:0]  sel;
   logic        exl_clr;

   assign irq  = (|(hw_int & im)) & ie & ~exl;
   assign take = (irq | exc_m) & (state == ST_RUN);

   cp0_regs u_cp0 (
      .clk        (clk),
      .reset      (reset),
      .hw_int     (hw_int),
      .take       (take),
      .irq        (irq),
      .exc_code_m (exc_code_m),
      .pc_m       (pc_m),
      .bd_m       (bd_m),
      .exl_clr    (exl_clr),
      .we         (cp0_we_m & ~take),
      .addr       (cp0_addr_m),
      .wdata      (cp0_wdata_m),
      .im         (im),
      .ie         (ie),
      .exl        (exl),
      .epc        (epc),
      .rdata      (rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      stall_eret  = 1'b0;
      redirect_ok = 1'b0;
      sel         = PCSEL_SEQ;
      case (state)
         ST_RUN: begin
            if (take) begin
               state_nxt = ST_ENTER;
            end else if (eret_d && epc_wr_pend) begin
               // EPC is still being written upstream; hold eret in D.
               stall_eret = 1'b1;
               state_nxt  = ST_ERET_WAIT;
            end else begin
               redirect_ok = 1'b1;
            end
         end
         ST_ENTER: begin
            // Handler's first fetch cycle: sequential, no flush, no retake.
            state_nxt = ST_RUN;
         end
         ST_ERET_WAIT: begin
            if (epc_wr_pend) begin
               stall_eret = 1'b1;
            end else begin
               // EPC has landed: the held eret may redirect this cycle.
               redirect_ok = 1'b1;
               state_nxt   = ST_RUN;
            end
         end
         default: state_nxt = ST_RUN;
      endcase

      if (redirect_ok && !stall) begin
         if (eret_d) begin
            sel = PCSEL_EPC;
         end else if (jr_d) begin
            sel = PCSEL_JR;
         end else if (br_taken_d || j_d) begin
            sel = PCSEL_NPC;
         end
      end
   end

   assign exl_clr = (sel == PCSEL_EPC);

   // Outputs read as 0 for as long as reset is held, independent of inputs.
   assign pc_sel     = reset ? PCSEL_SEQ : sel;
   assign int_take   = ~reset & take;
   assign flush      = ~reset & take;
   assign eret_stall = ~reset & stall_eret;
   assign epc_out    = reset ? 32'h0 : epc;
   assign cp0_rdata  = reset ? 32'h0 : rdata;
   assign dbg_state  = reset ? ST_RUN : state;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        br_taken_d, j_d, jr_d, eret_d;
   logic        exc_m;
   logic [4:0]  exc_code_m;
   logic [31:0] pc_m;
   logic        bd_m;
   logic [5:0]  hw_int;
   logic        cp0_we_m;
   logic [4:0]  cp0_addr_m;
   logic [31:0] cp0_wdata_m;
   logic        epc_wr_pend;
   logic [1:0]  pc_sel;
   logic        int_take;
   logic [31:0] epc_out;
   logic        flush;
   logic        eret_stall;
   logic [31:0] cp0_rdata;
   logic [1:0]  dbg_state;

   int n_cmp = 0;
   int n_bad = 0;

   pc_redirect_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .br_taken_d  (br_taken_d),
      .j_d         (j_d),
      .jr_d        (jr_d),
      .eret_d      (eret_d),
      .exc_m       (exc_m),
      .exc_code_m  (exc_code_m),
      .pc_m        (pc_m),
      .bd_m        (bd_m),
      .hw_int      (hw_int),
      .cp0_we_m    (cp0_we_m),
      .cp0_addr_m  (cp0_addr_m),
      .cp0_wdata_m (cp0_wdata_m),
      .epc_wr_pend (epc_wr_pend),
      .pc_sel      (pc_sel),
      .int_take    (int_take),
      .epc_out     (epc_out),
      .flush       (flush),
      .eret_stall  (eret_stall),
      .cp0_rdata   (cp0_rdata),
      .dbg_state   (dbg_state)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v)
      else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic rd(input logic [4:0] addr, input string tag, input logic [31:0] exp_v);
      cp0_addr_m = addr;
      #1;
      chk(tag, cp0_rdata, exp_v);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset = 1'b1;
      stall = 0; br_taken_d = 1; j_d = 0; jr_d = 1; eret_d = 0;
      exc_m = 0; exc_code_m = 0; pc_m = 0; bd_m = 0; hw_int = 0;
      cp0_we_m = 0; cp0_addr_m = 5'd12; cp0_wdata_m = 0; epc_wr_pend = 0;
      #3;
      // Outputs held at 0 during reset even with redirect inputs active
      chk("rst_pc_sel", {30'd0, pc_sel}, 32'd0);
      chk("rst_int_take", {31'd0, int_take}, 32'd0);
      chk("rst_flush", {31'd0, flush}, 32'd0);
      br_taken_d = 0; jr_d = 0;
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("rel_pc_sel", {30'd0, pc_sel}, 32'd0);
      chk("rel_eret_stall", {31'd0, eret_stall}, 32'd0);
      chk("rel_epc_out", epc_out, 32'd0);
      chk("rel_state", {30'd0, dbg_state}, 32'd0);
      rd(5'd12, "rel_sr", 32'd0);

      // mtc0 SR <- 0x401 (IM[0], IE)
      tick();
      cp0_we_m = 1; cp0_addr_m = 5'd12; cp0_wdata_m = 32'h0000_0401;
      tick();
      cp0_we_m = 0;
      rd(5'd12, "sr_write", 32'h0000_0401);

      // Interrupt on hw_int[0]
      hw_int = 6'b000001; pc_m = 32'h0000_1000;
      #1;
      chk("irq_int_take", {31'd0, int_take}, 32'd1);
      chk("irq_flush", {31'd0, flush}, 32'd1);
      chk("irq_pc_sel", {30'd0, pc_sel}, 32'd0);
      tick();
      chk("enter_int_take", {31'd0, int_take}, 32'd0);
      chk("enter_flush", {31'd0, flush}, 32'd0);
      chk("enter_state", {30'd0, dbg_state}, 32'd1);
      chk("irq_epc_out", epc_out, 32'h0000_1000);
      rd(5'd14, "irq_epc", 32'h0000_1000);
      rd(5'd12, "irq_sr_exl", 32'h0000_0403);
      rd(5'd13, "irq_cause", 32'h0000_0400);
      tick();
      // Back in RUN with EXL=1: the still-asserted line is ignored
      chk("exl_mask_int_take", {31'd0, int_take}, 32'd0);
      chk("exl_mask_state", {30'd0, dbg_state}, 32'd0);
      hw_int = 6'b000000;

      // Ov exception in a delay slot
      tick();
      exc_m = 1; exc_code_m = 5'd12; bd_m = 1; pc_m = 32'h0000_3010;
      #1;
      chk("exc_int_take", {31'd0, int_take}, 32'd1);
      chk("exc_flush", {31'd0, flush}, 32'd1);
      tick();
      exc_m = 0; bd_m = 0;
`ifdef PC_REDIRECT_BD_EN
      rd(5'd14, "exc_bd_epc", 32'h0000_300C);
      rd(5'd13, "exc_bd_cause", 32'h8000_0030);
`else
      rd(5'd14, "exc_bd_epc", 32'h0000_3010);
      rd(5'd13, "exc_bd_cause", 32'h0000_0030);
`endif
      tick();

      // eret with an EPC write pending for two cycles
      eret_d = 1; epc_wr_pend = 1;
      cp0_we_m = 1; cp0_addr_m = 5'd14; cp0_wdata_m = 32'h0000_2000;
      #1;
      chk("eret_w1_stall", {31'd0, eret_stall}, 32'd1);
      chk("eret_w1_pc_sel", {30'd0, pc_sel}, 32'd0);
      tick();
      cp0_we_m = 0;
      #1;
      chk("eret_w2_stall", {31'd0, eret_stall}, 32'd1);
      chk("eret_w2_pc_sel", {30'd0, pc_sel}, 32'd0);
      chk("eret_w2_state", {30'd0, dbg_state}, 32'd2);
      tick();
      epc_wr_pend = 0;
      #1;
      chk("eret_go_stall", {31'd0, eret_stall}, 32'd0);
      chk("eret_go_pc_sel", {30'd0, pc_sel}, 32'd3);
      chk("eret_go_epc_out", epc_out, 32'h0000_2000);
      tick();
      eret_d = 0;
      rd(5'd12, "eret_sr_exl_clr", 32'h0000_0401);
      chk("eret_state_run", {30'd0, dbg_state}, 32'd0);

      // pc_sel priority and stall override
      jr_d = 1; br_taken_d = 1;
      #1;
      chk("prio_jr_over_br", {30'd0, pc_sel}, 32'd1);
      tick();
      jr_d = 0;
      #1;
      chk("br_only", {30'd0, pc_sel}, 32'd2);
      tick();
      br_taken_d = 0; j_d = 1;
      #1;
      chk("j_only", {30'd0, pc_sel}, 32'd2);
      tick();
      j_d = 0; br_taken_d = 1; stall = 1;
      #1;
      chk("br_stalled", {30'd0, pc_sel}, 32'd0);
      tick();
      br_taken_d = 0; stall = 0; eret_d = 1;
      #1;
      chk("eret_no_hazard", {30'd0, pc_sel}, 32'd3);
      tick();
      eret_d = 0;

      // Interrupt and exception together; ENTER blocks a retake
      hw_int = 6'b000001; exc_m = 1; exc_code_m = 5'd10; pc_m = 32'h0000_5000;
      br_taken_d = 1;
      #1;
      chk("both_int_take", {31'd0, int_take}, 32'd1);
      tick();
      chk("both_enter_no_retake", {31'd0, int_take}, 32'd0);
      chk("both_enter_flush", {31'd0, flush}, 32'd0);
      chk("both_enter_pc_sel", {30'd0, pc_sel}, 32'd0);
      rd(5'd13, "both_cause_int", 32'h0000_0400);
      rd(5'd14, "both_epc", 32'h0000_5000);
      exc_m = 0; hw_int = 0; br_taken_d = 0;
      tick();

      // mtc0 EPC in the entry cycle is dropped
      exc_m = 1; exc_code_m = 5'd4; pc_m = 32'h0000_6000;
      cp0_we_m = 1; cp0_addr_m = 5'd14; cp0_wdata_m = 32'hDEAD_BEEF;
      tick();
      exc_m = 0; cp0_we_m = 0;
      rd(5'd14, "mtc0_dropped_epc", 32'h0000_6000);
      tick();

      // Cause write touches only IP[11:10]; PRId is read-only
      cp0_we_m = 1; cp0_addr_m = 5'd13; cp0_wdata_m = 32'hFFFF_FFFF;
      tick();
      cp0_we_m = 0;
      rd(5'd13, "cause_sw_ip", 32'h0000_0C10);
      cp0_we_m = 1; cp0_addr_m = 5'd15; cp0_wdata_m = 32'h0000_1234;
      tick();
      cp0_we_m = 0;
      rd(5'd15, "prid_ro", 32'h0000_0000);

      // Reset mid-operation
      jr_d = 1;
      reset = 1;
      #1;
      chk("midrst_pc_sel", {30'd0, pc_sel}, 32'd0);
      chk("midrst_epc_out", epc_out, 32'd0);
      tick();
      reset = 0; jr_d = 0;
      rd(5'd12, "midrst_sr", 32'd0);
      rd(5'd14, "midrst_epc", 32'd0);
      chk("midrst_state", {30'd0, dbg_state}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
